// File: rtl/aemb2_ich_pkg.sv
// Shared types and constants for the AEMB2 instruction-cache refill controller.
package aemb2_ich_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      FILL = 3'd1,
      PREF = 3'd2,
      RTRY = 3'd3,
      DONE = 3'd4
   } ich_state_e;

   localparam logic [3:0] ICH_SEL = 4'hF;

endpackage

// File: rtl/aemb2_ich_tmo.sv
// Bus timeout counter for the refill controller; tc_o flags a stalled bus cycle.
module aemb2_ich_tmo #(
   parameter int AEMB_TMO = 8
) (
   input  logic gclk,
   input  logic grst,
   input  logic clr_i,
   input  logic ena_i,
   output logic tc_o
);

   localparam logic [AEMB_TMO-1:0] CNT_ONE = {{(AEMB_TMO-1){1'b0}}, 1'b1};
   // Fire on the cycle whose increment would land on all-ones.
   localparam logic [AEMB_TMO-1:0] CNT_PRE = {{(AEMB_TMO-1){1'b1}}, 1'b0};

   logic [AEMB_TMO-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (ena_i)
         cnt_d = cnt_q + CNT_ONE;
   end

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = ena_i & (cnt_q == CNT_PRE);

endmodule

// File: rtl/aemb2_ich_fill.sv
// AEMB2 I-cache refill controller: stalls fetch on a miss, fills over Wishbone.
// Optional sequential prefetch when AEMB2_ICH_PREFETCH_EN is defined.
//
// state | meaning
// IDLE  | cache index follows fetch address, watching for a miss
// FILL  | demand word bus read, cache written on ack
// PREF  | next sequential word read in the same bus cycle
// RTRY  | one idle bus cycle after a demand timeout
// DONE  | bus idle, re-read the missed word so fetch resumes on a hit
module aemb2_ich_fill
   import aemb2_ich_pkg::*;
#(
   parameter int AEMB_IWB = 32,
   parameter int AEMB_ICH = 11,
   parameter int AEMB_TMO = 8
) (
   input  logic                gclk,
   input  logic                grst,
   input  logic                iena,
   input  logic                ich_req,
   input  logic [AEMB_IWB-1:2] fch_adr,
   input  logic [31:2]         rpc_if,
   input  logic                ich_hit,
   output logic [AEMB_IWB-1:2] ich_adr,
   output logic                ich_fil,
   output logic                ich_ena,
   output logic                ich_stall,
   output logic                ich_tmo,
   output logic [AEMB_IWB-1:2] iwb_adr_o,
   output logic                iwb_stb_o,
   output logic                iwb_cyc_o,
   output logic [3:0]          iwb_sel_o,
   output logic                iwb_wre_o,
   input  logic                iwb_ack_i
);

   localparam int AW = AEMB_IWB - 2;
   localparam logic [AW-1:0] ADR_ONE = {{(AW-1){1'b0}}, 1'b1};

   ich_state_e    state_q, state_d;
   logic [AW-1:0] fadr_q, fadr_d;
   logic          miss, busy, on_bus, tmo_tc;

   assign busy   = (state_q != IDLE);
   assign on_bus = (state_q == FILL) || (state_q == PREF);
   assign miss   = (state_q == IDLE) & ich_req & iena & ~ich_hit;

   aemb2_ich_tmo #(.AEMB_TMO(AEMB_TMO)) u_tmo (
      .gclk  (gclk),
      .grst  (grst),
      .clr_i (iwb_ack_i | ~on_bus),
      .ena_i (on_bus & ~iwb_ack_i),
      .tc_o  (tmo_tc)
   );

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         state_q <= IDLE;
         fadr_q  <= '0;
      end else begin
         state_q <= state_d;
         fadr_q  <= fadr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fadr_d  = miss ? rpc_if[AEMB_IWB-1:2] : fadr_q;
      unique case (state_q)
         IDLE: if (miss) state_d = FILL;
         FILL: begin
            if (iwb_ack_i) begin
`ifdef AEMB2_ICH_PREFETCH_EN
               state_d = PREF;
`else
               state_d = DONE;
`endif
            end else if (tmo_tc) begin
               state_d = RTRY;
            end
         end
         // A prefetch timeout is abandoned rather than retried.
         PREF: if (iwb_ack_i || tmo_tc) state_d = DONE;
         RTRY: state_d = FILL;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ich_adr   = fadr_q;
      iwb_adr_o = '0;
      if (state_q == IDLE)
         ich_adr = fch_adr;
      else if (state_q == PREF)
         ich_adr = fadr_q + ADR_ONE;
      if (on_bus)
         iwb_adr_o = ich_adr;
      iwb_stb_o = on_bus;
      iwb_cyc_o = on_bus;
      ich_fil   = on_bus;
      ich_tmo   = tmo_tc;
      ich_stall = miss | busy;
      ich_ena   = iena | busy;
      iwb_sel_o = ICH_SEL;
      iwb_wre_o = 1'b0;
   end

endmodule

// File: tb/tb_aemb2_ich_fill.sv
// Scoreboard bench for aemb2_ich_fill: cache writes, stall episodes and timeouts are checked by a monitor.
module tb_aemb2_ich_fill;

`ifdef AEMB2_ICH_PREFETCH_EN
   localparam bit PREF_ON = 1'b1;
`else
   localparam bit PREF_ON = 1'b0;
`endif

   logic        gclk, grst, iena, ich_req, ich_hit, iwb_ack_i;
   logic [31:2] fch_adr, rpc_if, ich_adr, iwb_adr_o;
   logic        ich_fil, ich_ena, ich_stall, ich_tmo, iwb_stb_o, iwb_cyc_o, iwb_wre_o;
   logic [3:0]  iwb_sel_o;

   aemb2_ich_fill #(.AEMB_IWB(32), .AEMB_ICH(11), .AEMB_TMO(3)) dut (
      .gclk(gclk), .grst(grst), .iena(iena), .ich_req(ich_req), .fch_adr(fch_adr),
      .rpc_if(rpc_if), .ich_hit(ich_hit), .ich_adr(ich_adr), .ich_fil(ich_fil),
      .ich_ena(ich_ena), .ich_stall(ich_stall), .ich_tmo(ich_tmo), .iwb_adr_o(iwb_adr_o),
      .iwb_stb_o(iwb_stb_o), .iwb_cyc_o(iwb_cyc_o), .iwb_sel_o(iwb_sel_o),
      .iwb_wre_o(iwb_wre_o), .iwb_ack_i(iwb_ack_i)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   typedef struct {
      int          len;
      logic [29:0] adr;
   } stall_t;

   int          checks = 0;
   int          errors = 0;
   logic [29:0] exp_wr[$];
   logic [29:0] exp_tmo[$];
   stall_t      exp_st[$];

   int ack_wait = 0;
   bit ack_en   = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h required=none", name, act);
   endtask

   // Wishbone slave: ack after ack_wait wait states, driven just after the clock edge.
   initial begin
      int wcnt;
      wcnt = 0;
      iwb_ack_i = 1'b0;
      forever begin
         @(posedge gclk);
         #1;
         if (grst && iwb_stb_o && ack_en) begin
            if (wcnt >= ack_wait) begin
               iwb_ack_i = 1'b1;
               wcnt = 0;
            end else begin
               iwb_ack_i = 1'b0;
               wcnt++;
            end
         end else begin
            iwb_ack_i = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT writes, times out or ends a stall.
   initial begin
      int          run;
      bit          prev_tmo;
      logic [29:0] last_adr, e;
      logic        last_cyc;
      stall_t      s;
      run = 0;
      prev_tmo = 1'b0;
      last_adr = '0;
      last_cyc = 1'b0;
      forever begin
         @(negedge gclk);
         if (!grst) begin
            run = 0;
            prev_tmo = 1'b0;
         end else begin
            if (ich_fil && iwb_ack_i) begin
               if (exp_wr.size() == 0) unexpected("unexp_write", ich_adr);
               else begin
                  e = exp_wr.pop_front();
                  chk("write_ich_adr", ich_adr, e);
                  chk("write_iwb_adr", iwb_adr_o, e);
               end
            end
            if (prev_tmo) chk("retry_bus_idle", iwb_cyc_o, 0);
            prev_tmo = ich_tmo;
            if (ich_tmo) begin
               if (exp_tmo.size() == 0) unexpected("unexp_tmo", ich_adr);
               else begin
                  e = exp_tmo.pop_front();
                  chk("tmo_adr", iwb_adr_o, e);
               end
            end
            if (ich_stall) begin
               run++;
               last_adr = ich_adr;
               last_cyc = iwb_cyc_o;
            end else if (run > 0) begin
               if (exp_st.size() == 0) unexpected("unexp_stall", run);
               else begin
                  s = exp_st.pop_front();
                  chk("stall_len", run, s.len);
                  chk("done_ich_adr", last_adr, s.adr);
                  chk("done_bus_idle", last_cyc, 0);
               end
               run = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge gclk);
      #2;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (n < 60) begin
         @(negedge gclk);
         if (!ich_stall) break;
         n++;
      end
      if (n >= 60) unexpected({name, "_stall_timeout"}, n);
      step();
   endtask

   // Pushes the expected writes/stall for a miss at adr with w wait states per word.
   task automatic expect_miss(input logic [29:0] adr, input int w, input int extra);
      logic [29:0] nxt;
      stall_t      s;
      nxt = adr + 30'd1;
      exp_wr.push_back(adr);
      if (PREF_ON) exp_wr.push_back(nxt);
      s.len = 1 + (w + 1) + 1 + extra + (PREF_ON ? (w + 1) : 0);
      s.adr = adr;
      exp_st.push_back(s);
   endtask

   task automatic start_miss(input logic [29:0] adr, input int w);
      ack_wait = w;
      rpc_if   = adr;
      ich_req  = 1'b1;
      ich_hit  = 1'b0;
      iena     = 1'b1;
      step();
      ich_req  = 1'b0;
      ich_hit  = 1'b1;
   endtask

   initial begin
      int n;
      bit found;
      stall_t s;
      grst = 1'b0; iena = 1'b0; ich_req = 1'b0; ich_hit = 1'b0;
      fch_adr = '0; rpc_if = '0;
      #12;
      chk("rst_stb", iwb_stb_o, 0);
      chk("rst_cyc", iwb_cyc_o, 0);
      chk("rst_fil", ich_fil, 0);
      chk("rst_stall", ich_stall, 0);
      chk("rst_tmo", ich_tmo, 0);
      chk("rst_ena", ich_ena, 0);
      chk("rst_iwb_adr", iwb_adr_o, 0);
      chk("rst_sel", iwb_sel_o, 4'hF);
      chk("rst_wre", iwb_wre_o, 0);
      step();
      grst = 1'b1;
      step();

      // Single miss, 2 wait states: address held 3 cycles, 5 stall cycles.
      expect_miss(30'h100, 2, 0);
      start_miss(30'h100, 2);
      for (int i = 0; i < 3; i++) begin
         @(negedge gclk);
         chk("single_stb", iwb_stb_o, 1);
         chk("single_adr", iwb_adr_o, 30'h100);
      end
      wait_idle("single");

      // Best case: 3 stall cycles.
      expect_miss(30'h2A5, 0, 0);
      start_miss(30'h2A5, 0);
      wait_idle("best");

      // Top-of-space miss; prefetch wraps to zero.
      expect_miss(30'h3FFFFFFF, 1, 0);
      start_miss(30'h3FFFFFFF, 1);
      wait_idle("wrap");

      // Hit stream.
      for (int i = 0; i < 20; i++) begin
         fch_adr = 30'h40 + 30'(i * 3);
         rpc_if  = 30'h500 + 30'(i);
         ich_req = 1'b1;
         ich_hit = 1'b1;
         iena    = 1'b1;
         @(negedge gclk);
         chk("hit_ich_adr", ich_adr, fch_adr);
         chk("hit_stall", ich_stall, 0);
         chk("hit_stb", iwb_stb_o, 0);
         step();
      end
      ich_req = 1'b0;

      // Miss while pipeline disabled is ignored.
      iena = 1'b0; ich_req = 1'b1; ich_hit = 1'b0; rpc_if = 30'h999;
      for (int i = 0; i < 4; i++) begin
         @(negedge gclk);
         chk("noena_stall", ich_stall, 0);
         chk("noena_ena", ich_ena, 0);
         chk("noena_stb", iwb_stb_o, 0);
         step();
      end
      ich_req = 1'b0; ich_hit = 1'b1;

      // Cache stays enabled during a fill with iena low.
      expect_miss(30'h77, 1, 0);
      start_miss(30'h77, 1);
      iena = 1'b0;
      @(negedge gclk);
      chk("fill_ena", ich_ena, 1);
      wait_idle("fill_ena");
      iena = 1'b1;

      // Timeout: 7 FILL cycles, retry cycle, then a completing fill.
      exp_tmo.push_back(30'h55);
      expect_miss(30'h55, 0, 8);
      ack_en = 1'b0;
      start_miss(30'h55, 0);
      n = 0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge gclk);
         if (iwb_stb_o) n++;
         if (ich_tmo) begin
            found = 1'b1;
            break;
         end
      end
      chk("tmo_seen", found, 1);
      chk("tmo_fill_cycles", n, 7);
      step();
      ack_en = 1'b1;
      ack_wait = 0;
      wait_idle("tmo");

      // Reset mid-fill drops the bus at once and nothing is written afterwards.
      ack_en = 1'b0;
      start_miss(30'h1234, 0);
      @(negedge gclk);
      @(negedge gclk);
      #2;
      grst = 1'b0;
      #1;
      chk("midrst_stb", iwb_stb_o, 0);
      chk("midrst_cyc", iwb_cyc_o, 0);
      chk("midrst_fil", ich_fil, 0);
      chk("midrst_stall", ich_stall, 0);
      ack_en = 1'b1;
      step();
      step();
      grst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge gclk);
         chk("postrst_stall", ich_stall, 0);
         chk("postrst_stb", iwb_stb_o, 0);
      end
      step();

      repeat (3) step();
      chk("wr_left", exp_wr.size(), 0);
      chk("stall_left", exp_st.size(), 0);
      chk("tmo_left", exp_tmo.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/aemb2_ich_fill.md
# aemb2_ich_fill

Refill controller for the AEMB2 instruction cache. It watches the cache hit result for each fetch lookup and, on a miss, stalls the fetch stage. It then runs a Wishbone read for the missing word and drives the cache fill strobe and index so the returned word and its tag/check are written. Finally it re-reads the line so the pipeline resumes on a hit. It sits between the fetch stage, the instruction cache block and the instruction Wishbone master port.

## Interface
- AEMB_IWB, 32: instruction bus address width.
- AEMB_ICH, 11: cache index width. It must match the cache block.
- AEMB_TMO, 8: width of the bus timeout counter.

Ports:
- gclk  in  1  clock, rising edge.
- grst  in  1  reset, asynchronous, active-low.
- iena  in  1  pipeline enable from the fetch stage.
- ich_req  in  1  a fetch lookup is valid this cycle.
- fch_adr  in  [AEMB_IWB-1:2]  next lookup address, passed to the cache index while idle.
- rpc_if  in  [31:2]  address whose hit is reported this cycle.
- ich_hit  in  1  hit result from the cache.
- ich_adr  out  [AEMB_IWB-1:2]  cache index (read and write).
- ich_fil  out  1  fill strobe to the cache. The cache writes on ich_fil & iwb_ack_i.
- ich_ena  out  1  cache RAM enable; ich_ena = iena | busy.
- ich_stall  out  1  stalls the fetch stage.
- ich_tmo  out  1  one-cycle pulse when a bus timeout occurs.
- iwb_adr_o  out  [AEMB_IWB-1:2]  Wishbone address.
- iwb_stb_o, iwb_cyc_o  out  1  Wishbone strobe and cycle.
- iwb_sel_o  out  4  fixed 4'hF.
- iwb_wre_o  out  1  fixed 0.
- iwb_ack_i  in  1  Wishbone acknowledge.

## Operation
- States: IDLE, FILL, PREF, RTRY, DONE.
- Miss: a miss is ich_req & iena & !ich_hit while in IDLE.
  - On a miss, the controller latches fadr = rpc_if[AEMB_IWB-1:2] and enters FILL.
- ich_adr selection: fch_adr in IDLE; fadr in FILL, RTRY and DONE; fadr+1 in PREF.
- FILL:
  - iwb_stb_o, iwb_cyc_o and ich_fil are all 1.
  - iwb_adr_o = ich_adr.
  - On ack: go to PREF if prefetch is compiled in, else DONE.
- PREF:
  - Same bus cycle. iwb_cyc_o stays high with no gap.
  - Address is fadr+1, modulo 2^(AEMB_IWB-2); wrap-around is allowed.
  - On ack: go to DONE.
- DONE:
  - One cycle with bus idle and ich_fil=0.
  - Re-reads fadr, then returns to IDLE.
- Timeout:
  - The counter clears on entering FILL or PREF and on every ack.
  - It increments on each FILL/PREF cycle without an ack.
  - At all-ones:
    - In FILL: pulse ich_tmo and go to RTRY, which holds the bus idle for one cycle, then re-enter FILL at the same address.
    - In PREF: pulse ich_tmo and abandon the prefetch, going to DONE. No retry.
- ich_stall = (IDLE & miss) | (state != IDLE).
- busy = (state != IDLE).
- A miss while iena=0 is ignored.
- A hit in IDLE never leaves IDLE.
- An ack outside FILL/PREF is ignored.

## Timing
- Reset values: state IDLE; all outputs 0 except iwb_sel_o = 4'hF; counter 0.
- Reset mid-fill: stb, cyc and fil drop asynchronously, and no write occurs after release.
- Best case, ack on the first FILL cycle with no prefetch: the miss cycle, FILL and DONE are stalled, i.e. 3 stall cycles; the hit is seen on the fourth cycle.
- Each additional wait state adds one cycle. Prefetch adds at least one cycle.
- Wishbone is classic single-cycle-ack: stb and address are held until ack.
- The bus returns idle the cycle after the final ack.

## Configuration
- AEMB2_ICH_PREFETCH_EN defined: after the demand ack, the next sequential word is fetched through PREF, and the stall is held until its ack or timeout.
- Undefined: the PREF state is unreachable and FILL goes directly to DONE.

## Structure
- Package aemb2_ich_pkg holds:
  - the state enumeration (IDLE, FILL, PREF, RTRY, DONE);
  - the iwb_sel_o constant 4'hF.
- Sub-module aemb2_ich_tmo: an AEMB_TMO-bit timeout counter with clear and enable inputs and a terminal-count output.

## Test plan
- Reset: assert grst=0 mid-FILL -> stb, cyc, fil and stall read 0 immediately; state is IDLE after release.
- Single miss: rpc_if=30'h100, hit=0, ack after 2 wait states -> iwb_adr_o=30'h100 for 3 cycles; ich_fil&ack writes exactly once; stall is high 5 cycles; ich_adr=30'h100 in DONE.
- Hit stream: ich_hit=1 for 20 requests -> stall, stb and fil never assert; ich_adr tracks fch_adr.
- Timeout, with AEMB_TMO=3 and no ack: 7 FILL cycles -> ich_tmo pulse, 1 idle bus cycle, FILL again at the same address; an ack then completes normally.
- Prefetch on, miss at 30'h3FFFFFFF: the second bus address is 30'h0, cyc is continuous across both acks, and there are 2 writes.
- iena=0 with hit=0: no fill starts. During a fill, ich_ena=1 while iena=0.
